// File: rtl/axi_line_master.sv
// AXI4 line master: moves one whole cache line per request, as a single INCR
// read burst (refill) or a single INCR write burst (writeback).
module axi_line_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MASTER_ID  = 0
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  // Cache controller side
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
  output logic                             done,
  output logic                             done_err,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rline,
  // Write address channel
  output logic [ID_WIDTH-1:0]              m_AWID,
  output logic [ADDR_WIDTH-1:0]            m_AWADDR,
  output logic [7:0]                       m_AWLEN,
  output logic [2:0]                       m_AWSIZE,
  output logic [1:0]                       m_AWBURST,
  output logic                             m_AWVALID,
  input  logic                             m_AWREADY,
  // Write data channel
  output logic [DATA_WIDTH-1:0]            m_WDATA,
  output logic [DATA_WIDTH/8-1:0]          m_WSTRB,
  output logic                             m_WLAST,
  output logic                             m_WVALID,
  input  logic                             m_WREADY,
  // Write response channel
  input  logic [ID_WIDTH-1:0]              m_BID,
  input  logic [1:0]                       m_BRESP,
  input  logic                             m_BVALID,
  output logic                             m_BREADY,
  // Read address channel
  output logic [ID_WIDTH-1:0]              m_ARID,
  output logic [ADDR_WIDTH-1:0]            m_ARADDR,
  output logic [7:0]                       m_ARLEN,
  output logic [2:0]                       m_ARSIZE,
  output logic [1:0]                       m_ARBURST,
  output logic                             m_ARVALID,
  input  logic                             m_ARREADY,
  // Read data channel
  input  logic [ID_WIDTH-1:0]              m_RID,
  input  logic [DATA_WIDTH-1:0]            m_RDATA,
  input  logic [1:0]                       m_RRESP,
  input  logic                             m_RLAST,
  input  logic                             m_RVALID,
  output logic                             m_RREADY,
  // Sideband, all tied off / ignored
  output logic                             m_AxLOCK,
  output logic [3:0]                       m_AxCACHE,
  output logic [2:0]                       m_AxPROT,
  output logic [3:0]                       m_AxQOS,
  output logic [3:0]                       m_AxREGION,
  output logic [USER_WIDTH-1:0]            m_AxUSER,
  output logic [USER_WIDTH-1:0]            m_WUSER,
  input  logic [USER_WIDTH-1:0]            m_BUSER,
  input  logic [USER_WIDTH-1:0]            m_RUSER
);

  localparam int unsigned CNT_WIDTH   = $clog2(LINE_WORDS);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int unsigned SIZE_CODE   = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    StIdle, StAr, StR, StRFin, StAw, StW, StB, StDone
  } state_e;

  state_e                                 state_q;
  logic [CNT_WIDTH-1:0]                   cnt_q;
  logic                                   err_q;
  logic [ADDR_WIDTH-1:0]                  addr_q;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  wline_q;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  rline_q;
  logic                                   arvalid_q;
  logic                                   rready_q;
  logic                                   awvalid_q;
  logic                                   wvalid_q;
  logic                                   bready_q;
  logic                                   done_q;
  logic                                   done_err_q;
  logic                                   last_beat;

  assign last_beat = (cnt_q == CNT_WIDTH'(LINE_WORDS - 1));

  // Single FSM: payload and all handshake/status outputs are registered here.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wline_q    <= '0;
      rline_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            wline_q <= req_wline;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            if (req_write) begin
              awvalid_q <= 1'b1;
              state_q   <= StAw;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
        end
        StAr: begin
          if (m_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          if (m_RVALID) begin
            rline_q[cnt_q] <= m_RDATA;
            // RLAST must line up with our own beat count; it never ends the burst.
            if ((m_RRESP != 2'b00) || (m_RLAST != last_beat)) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              cnt_q    <= '0;
              rready_q <= 1'b0;
              state_q  <= StRFin;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        StRFin: begin
          // Final beat and its error contribution are now registered.
          done_q     <= 1'b1;
          done_err_q <= err_q;
          state_q    <= StDone;
        end
        StAw: begin
          if (m_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= StW;
          end
        end
        StW: begin
          if (m_WREADY) begin
            if (last_beat) begin
              cnt_q    <= '0;
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        StB: begin
          if (m_BVALID) begin
            bready_q   <= 1'b0;
            err_q      <= err_q | (m_BRESP != 2'b00);
            done_q     <= 1'b1;
            done_err_q <= err_q | (m_BRESP != 2'b00);
            state_q    <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign rline     = rline_q;

  assign m_AWID    = ID_WIDTH'(MASTER_ID);
  assign m_AWADDR  = addr_q;
  assign m_AWLEN   = 8'(LINE_WORDS - 1);
  assign m_AWSIZE  = 3'(SIZE_CODE);
  assign m_AWBURST = 2'b01;
  assign m_AWVALID = awvalid_q;

  // WDATA/WLAST are a mux of registered state, so they hold while WREADY is low.
  assign m_WDATA   = wline_q[cnt_q];
  assign m_WSTRB   = '1;
  assign m_WLAST   = last_beat & wvalid_q;
  assign m_WVALID  = wvalid_q;

  assign m_BREADY  = bready_q;

  assign m_ARID    = ID_WIDTH'(MASTER_ID);
  assign m_ARADDR  = addr_q;
  assign m_ARLEN   = 8'(LINE_WORDS - 1);
  assign m_ARSIZE  = 3'(SIZE_CODE);
  assign m_ARBURST = 2'b01;
  assign m_ARVALID = arvalid_q;

  assign m_RREADY  = rready_q;

  assign m_AxLOCK   = 1'b0;
  assign m_AxCACHE  = '0;
  assign m_AxPROT   = '0;
  assign m_AxQOS    = '0;
  assign m_AxREGION = '0;
  assign m_AxUSER   = '0;
  assign m_WUSER    = '0;

  logic unused_inputs;
  assign unused_inputs = ^{m_BID, m_RID, m_BUSER, m_RUSER, req_addr[OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master with default parameters (32-bit data, 4-word line).
module tb_axi_line_master;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wline = '0;
  logic         done;
  logic         done_err;
  logic [127:0] rline;
  logic [1:0]   m_AWID;
  logic [31:0]  m_AWADDR;
  logic [7:0]   m_AWLEN;
  logic [2:0]   m_AWSIZE;
  logic [1:0]   m_AWBURST;
  logic         m_AWVALID;
  logic         m_AWREADY = 1'b0;
  logic [31:0]  m_WDATA;
  logic [3:0]   m_WSTRB;
  logic         m_WLAST;
  logic         m_WVALID;
  logic         m_WREADY = 1'b0;
  logic [1:0]   m_BID = '0;
  logic [1:0]   m_BRESP = '0;
  logic         m_BVALID = 1'b0;
  logic         m_BREADY;
  logic [1:0]   m_ARID;
  logic [31:0]  m_ARADDR;
  logic [7:0]   m_ARLEN;
  logic [2:0]   m_ARSIZE;
  logic [1:0]   m_ARBURST;
  logic         m_ARVALID;
  logic         m_ARREADY = 1'b0;
  logic [1:0]   m_RID = '0;
  logic [31:0]  m_RDATA = '0;
  logic [1:0]   m_RRESP = '0;
  logic         m_RLAST = 1'b0;
  logic         m_RVALID = 1'b0;
  logic         m_RREADY;
  logic         m_AxLOCK;
  logic [3:0]   m_AxCACHE;
  logic [2:0]   m_AxPROT;
  logic [3:0]   m_AxQOS;
  logic [3:0]   m_AxREGION;
  logic [3:0]   m_AxUSER;
  logic [3:0]   m_WUSER;
  logic [3:0]   m_BUSER = '0;
  logic [3:0]   m_RUSER = '0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 ACLK = ~ACLK;

  axi_line_master dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wline  (req_wline),
    .done       (done),
    .done_err   (done_err),
    .rline      (rline),
    .m_AWID     (m_AWID),
    .m_AWADDR   (m_AWADDR),
    .m_AWLEN    (m_AWLEN),
    .m_AWSIZE   (m_AWSIZE),
    .m_AWBURST  (m_AWBURST),
    .m_AWVALID  (m_AWVALID),
    .m_AWREADY  (m_AWREADY),
    .m_WDATA    (m_WDATA),
    .m_WSTRB    (m_WSTRB),
    .m_WLAST    (m_WLAST),
    .m_WVALID   (m_WVALID),
    .m_WREADY   (m_WREADY),
    .m_BID      (m_BID),
    .m_BRESP    (m_BRESP),
    .m_BVALID   (m_BVALID),
    .m_BREADY   (m_BREADY),
    .m_ARID     (m_ARID),
    .m_ARADDR   (m_ARADDR),
    .m_ARLEN    (m_ARLEN),
    .m_ARSIZE   (m_ARSIZE),
    .m_ARBURST  (m_ARBURST),
    .m_ARVALID  (m_ARVALID),
    .m_ARREADY  (m_ARREADY),
    .m_RID      (m_RID),
    .m_RDATA    (m_RDATA),
    .m_RRESP    (m_RRESP),
    .m_RLAST    (m_RLAST),
    .m_RVALID   (m_RVALID),
    .m_RREADY   (m_RREADY),
    .m_AxLOCK   (m_AxLOCK),
    .m_AxCACHE  (m_AxCACHE),
    .m_AxPROT   (m_AxPROT),
    .m_AxQOS    (m_AxQOS),
    .m_AxREGION (m_AxREGION),
    .m_AxUSER   (m_AxUSER),
    .m_WUSER    (m_WUSER),
    .m_BUSER    (m_BUSER),
    .m_RUSER    (m_RUSER)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Zero-wait refill. base+b is beat b's data; bad_resp goes on beat 2; RLAST on beat rlast_at.
  task automatic run_refill(input logic [31:0] addr, input logic [31:0] base,
                            input logic [1:0] bad_resp, input int rlast_at, input logic exp_err);
    int           cyc;
    int           guard;
    logic [127:0] exp_line;
    exp_line  = '0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    check("ref_req_ready", req_ready, 1);
    tick();
    cyc       = 1;  // acceptance cycle is cycle 0
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    check("ref_arvalid", m_ARVALID, 1);
    check("ref_araddr", m_ARADDR, {addr[31:4], 4'h0});
    check("ref_arlen", m_ARLEN, 3);
    check("ref_arsize", m_ARSIZE, 2);
    check("ref_arburst", m_ARBURST, 1);
    check("ref_arid", m_ARID, 0);
    m_ARREADY = 1'b1;
    tick();
    cyc++;
    m_ARREADY = 1'b0;
    check("ref_arvalid_drop", m_ARVALID, 0);
    for (int b = 0; b < 4; b++) begin
      m_RVALID = 1'b1;
      m_RDATA  = base + 32'(b);
      m_RRESP  = (b == 2) ? bad_resp : 2'b00;
      m_RLAST  = (b == rlast_at);
      guard = 0;
      while (!m_RREADY && guard < 20) begin
        tick();
        cyc++;
        guard++;
      end
      if (guard == 20) check("ref_rready_timeout", m_RREADY, 1);
      tick();
      cyc++;
      exp_line[b*32 +: 32] = base + 32'(b);
    end
    m_RVALID = 1'b0;
    m_RLAST  = 1'b0;
    m_RRESP  = 2'b00;
    guard = 0;
    while (!done && guard < 20) begin
      tick();
      cyc++;
      guard++;
    end
    check("ref_done_cycle", cyc, 7);
    check("ref_done_err", done_err, exp_err);
    check("ref_rline", rline, exp_line);
    tick();
    check("ref_done_pulse", done, 0);
    check("ref_ready_after", req_ready, 1);
    check("ref_rline_hold", rline, exp_line);
  endtask

  // Writeback with aw_wait cycles of AWREADY low and optionally toggling WREADY.
  task automatic run_wb(input logic [31:0] addr, input logic [127:0] line, input int aw_wait,
                        input bit toggle, input logic [1:0] bresp, input logic exp_err);
    int   b;
    int   guard;
    logic wr;
    logic exp_last;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wline = line;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wline = '1;
    for (int i = 0; i < aw_wait; i++) begin
      check("wb_awvalid_wait", m_AWVALID, 1);
      check("wb_awaddr_wait", m_AWADDR, {addr[31:4], 4'h0});
      check("wb_no_early_w", m_WVALID, 0);
      tick();
    end
    check("wb_awvalid", m_AWVALID, 1);
    check("wb_awaddr", m_AWADDR, {addr[31:4], 4'h0});
    check("wb_awlen", m_AWLEN, 3);
    check("wb_awsize", m_AWSIZE, 2);
    check("wb_awburst", m_AWBURST, 1);
    check("wb_no_early_w", m_WVALID, 0);
    m_AWREADY = 1'b1;
    tick();
    m_AWREADY = 1'b0;
    b     = 0;
    guard = 0;
    wr    = !toggle;
    while (b < 4 && guard < 40) begin
      m_WREADY = wr;
      if (m_WVALID) begin
        exp_last = (b == 3);
        check("wb_wdata", m_WDATA, line[b*32 +: 32]);
        check("wb_wlast", m_WLAST, exp_last);
        check("wb_wstrb", m_WSTRB, 4'hF);
        if (wr) b++;
      end
      tick();
      guard++;
      if (toggle) wr = !wr;
    end
    if (b < 4) check("wb_w_timeout", b, 4);
    m_WREADY = 1'b0;
    check("wb_wvalid_drop", m_WVALID, 0);
    m_BVALID = 1'b1;
    m_BRESP  = bresp;
    guard = 0;
    while (!m_BREADY && guard < 20) begin
      tick();
      guard++;
    end
    if (guard == 20) check("wb_bready_timeout", m_BREADY, 1);
    tick();
    m_BVALID = 1'b0;
    m_BRESP  = 2'b00;
    check("wb_done", done, 1);
    check("wb_done_err", done_err, exp_err);
    check("wb_ready_in_done", req_ready, 0);
    tick();
    check("wb_done_pulse", done, 0);
    check("wb_ready_after", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    tick();
    tick();
    ARESET = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {m_ARVALID, m_AWVALID, m_WVALID}, 3'b000);
    check("rst_readys", {m_RREADY, m_BREADY}, 2'b00);
    check("rst_done", {done, done_err}, 2'b00);
    check("rst_rline", rline, 0);

    run_refill(32'h0000_1234, 32'hA0, 2'b00, 3, 1'b0);
    run_wb(32'h0000_5678, {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000},
           3, 1'b1, 2'b00, 1'b0);
    run_refill(32'h0000_2000, 32'hB0, 2'b10, 3, 1'b1);
    run_refill(32'h0000_3008, 32'hE0, 2'b00, 1, 1'b1);
    run_wb(32'h0000_4444, {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000},
           0, 1'b0, 2'b11, 1'b1);

    // Reset in the middle of a writeback, during beat 2.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_7000;
    req_wline = {32'h7, 32'h6, 32'h5, 32'h4};
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    m_AWREADY = 1'b1;
    tick();
    m_AWREADY = 1'b0;
    m_WREADY  = 1'b1;
    tick();
    tick();
    check("mid_wvalid", m_WVALID, 1);
    check("mid_wdata_beat2", m_WDATA, 32'h6);
    ARESET   = 1'b1;
    m_WREADY = 1'b0;
    tick();
    ARESET = 1'b0;
    check("mid_rst_valids", {m_ARVALID, m_AWVALID, m_WVALID}, 3'b000);
    check("mid_rst_readys", {m_RREADY, m_BREADY}, 2'b00);
    check("mid_rst_req_ready", req_ready, 1);
    saw_done = done;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done = saw_done | done;
    end
    check("mid_rst_no_done", saw_done, 0);
    run_refill(32'h0000_ABCC, 32'hC0, 2'b00, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- AXI4 master that moves whole cache lines between a cache controller and main memory.
- It is the initiator paired with the memory-side AXI slave: it issues one INCR read burst to refill a line, or one INCR write burst to write a line back.
- It sits between the cache coherence controller (simple request/done interface) and the interconnect or memory AXI slave port.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 2, AXI ID width.
- USER_WIDTH, 4, AXI user width.
- LINE_WORDS, 4, beats per line; power of 2, range 2..16.
- MASTER_ID, 0, value driven on m_AWID and m_ARID.

Ports:
- ACLK  input  1  clock.
- ARESET  input  1  synchronous, active-high reset.
- req_valid  input  1  line request valid.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1 = writeback, 0 = refill.
- req_addr  input  ADDR_WIDTH  line address; offset bits are ignored.
- req_wline  input  LINE_WORDS*DATA_WIDTH  writeback data; word0 in the LSBs.
- done  output  1  one-cycle pulse when the transaction completes.
- done_err  output  1  valid with done; 1 if any response was non-OKAY or RLAST was wrong.
- rline  output  LINE_WORDS*DATA_WIDTH  refill data; stable from done until the next accepted request.
- m_AWID/m_AWADDR/m_AWLEN/m_AWSIZE/m_AWBURST  output  ID/ADDR/8/3/2  write address channel.
- m_AWVALID  output  1 / m_AWREADY  input  1.
- m_WDATA/m_WSTRB/m_WLAST/m_WVALID  output  DATA/STRB/1/1; m_WREADY  input  1.
- m_BID/m_BRESP/m_BVALID  input  ID/2/1; m_BREADY  output  1.
- m_ARID/m_ARADDR/m_ARLEN/m_ARSIZE/m_ARBURST  output  ID/ADDR/8/3/2  read address channel.
- m_ARVALID  output  1 / m_ARREADY  input  1.
- m_RID/m_RDATA/m_RRESP/m_RLAST/m_RVALID  input  ID/DATA/2/1/1; m_RREADY  output  1.
- m_AxLOCK/m_AxCACHE/m_AxPROT/m_AxQOS/m_AxREGION/m_AxUSER, m_WUSER  output  1/4/3/4/4/USER_WIDTH  all tied to 0.
- m_BUSER/m_RUSER  input  USER_WIDTH  ignored.

Behaviour:
- Reset (ARESET high at a clock edge): state = IDLE; all VALID/READY outputs and done/done_err = 0; rline = 0; beat counter = 0. This applies mid-burst too: the transaction is abandoned and no done is issued.
- Constant outputs:
  - AxLEN = LINE_WORDS-1.
  - AxSIZE = log2(DATA_WIDTH/8).
  - AxBURST = 2'b01 (INCR).
  - AxID = MASTER_ID.
  - WSTRB = all ones.
- Address: AxADDR = req_addr with the low log2(LINE_WORDS*DATA_WIDTH/8) bits cleared. It is registered on acceptance.
- Request acceptance: req_valid && req_ready in IDLE. The controller registers req_write, the address and req_wline, and clears the error flag.
- FSM:
  - IDLE -> AR if req_write = 0, else -> AW.
  - AR: ARVALID = 1, held with stable payload until ARREADY. On handshake -> R.
  - R: RREADY = 1. Each RVALID&&RREADY beat writes RDATA into rline word [cnt], then cnt++.
    - Error flag is set if RRESP != 0.
    - Error flag is set if RLAST = 1 with cnt != LINE_WORDS-1, or RLAST = 0 with cnt == LINE_WORDS-1.
    - After beat LINE_WORDS-1 -> DONE. The beat count alone ends the burst; RLAST does not.
  - AW: AWVALID = 1, held until AWREADY -> W. WVALID is never raised before the AW handshake.
  - W: WVALID = 1, WDATA = line word [cnt], WLAST = (cnt == LINE_WORDS-1). Payload is held until WREADY. After the last beat -> B.
  - B: BREADY = 1. On BVALID, error flag |= (BRESP != 0) -> DONE. BID is not checked.
  - DONE: done = 1 and done_err = error flag for exactly one cycle -> IDLE. req_ready = 0 during DONE.
- Latency: refill done is issued no earlier than 2 cycles after the last R beat handshake cycle: the beat registers, then DONE. Minimum refill = LINE_WORDS + 3 cycles from acceptance with zero-wait slave.
- Handshakes: VALID is never deasserted before READY; payload is stable while VALID && !READY. READY signals do not depend combinationally on VALID.
- Counter: width clog2(LINE_WORDS); wraps to 0 on leaving R or W.
- Only one outstanding transaction. req_* changes outside acceptance are ignored.

Test Plan:
- Refill, zero-wait slave, req_addr=0x0000_1234, LINE_WORDS=4:
  - ARADDR=0x1230, ARLEN=3, ARSIZE=2, ARBURST=1.
  - R beats 0xA0..0xA3 -> rline={A3,A2,A1,A0}, done pulse at acceptance+7, done_err=0.
- Writeback with AWREADY delayed 3 cycles and WREADY toggling every cycle:
  - AWADDR held stable.
  - No WVALID before the AW handshake.
  - 4 beats in order with WLAST only on the 4th; BRESP=OKAY -> done_err=0.
- Refill where beat 2 has RRESP=2'b10 -> all 4 words captured, done_err=1.
- Refill where RLAST is asserted on beat 1 -> done_err=1; FSM still consumes 4 beats, then done.
- Writeback with BRESP=2'b11 -> done_err=1; req_ready returns 1 the cycle after done.
- ARESET pulse during the W state (beat 2) -> next cycle all VALIDs=0, req_ready=1, no done. A new refill then completes normally.
